// File: rtl/axi_line_mem_pkg.sv
// AXI4 channel and bundle types, plus burst/response encodings, shared by the
// line-memory responder and the benches that drive it.
package axi_line_mem_pkg;

  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned StrbWidth = DataWidth / 8;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic [5:0]           atop;
  } aw_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } ar_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;

endpackage

// File: rtl/axi_line_mem_responder.sv
// AXI4 subordinate serving cache refill reads and write-back bursts from a word
// array; independent read and write FSMs share the array, one burst each.
module axi_line_mem_responder #(
  parameter int unsigned AxiAddrWidth = axi_line_mem_pkg::AddrWidth,
  parameter int unsigned AxiDataWidth = axi_line_mem_pkg::DataWidth,
  parameter int unsigned AxiIdWidth   = axi_line_mem_pkg::IdWidth,
  parameter type         axi_req_t    = axi_line_mem_pkg::axi_req_t,
  parameter type         axi_rsp_t    = axi_line_mem_pkg::axi_rsp_t,
  parameter int unsigned NumWords     = 1024,
  parameter int unsigned ReadLatency  = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  axi_req_t axi_req_i,
  output axi_rsp_t axi_rsp_o,
  output logic     busy_o
);
  import axi_line_mem_pkg::*;

  localparam int unsigned StrbW = AxiDataWidth / 8;
  localparam int unsigned Off   = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(NumWords);
  localparam logic [3:0]  LatLast = (ReadLatency == 0) ? 4'd0 : 4'(ReadLatency - 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  function automatic idx_t addr_to_idx(input logic [AxiAddrWidth-1:0] addr);
    return addr[Off+IdxW-1:Off];
  endfunction

  logic [AxiDataWidth-1:0] mem [NumWords];

  r_state_e              r_state_q, r_state_d;
  idx_t                  r_idx_q, r_idx_d;
  logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [3:0]            r_lat_q, r_lat_d;
  logic [AxiIdWidth-1:0] r_id_q, r_id_d;
  logic                  r_err_q, r_err_d;

  w_state_e              w_state_q, w_state_d;
  idx_t                  w_idx_q, w_idx_d;
  logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [AxiIdWidth-1:0] w_id_q, w_id_d;
  logic                  w_err_q, w_err_d;
  logic                  w_atop_q, w_atop_d;
  logic                  mem_we;

  // Offset bits, wrapped-away upper bits and AxSIZE play no part in indexing.
  logic unused_fields;
  assign unused_fields = ^{axi_req_i.ar.addr[AxiAddrWidth-1:Off+IdxW], axi_req_i.ar.addr[Off-1:0],
                           axi_req_i.aw.addr[AxiAddrWidth-1:Off+IdxW], axi_req_i.aw.addr[Off-1:0],
                           axi_req_i.ar.size, axi_req_i.aw.size};

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_lat_q   <= '0;
      r_id_q    <= '0;
      r_err_q   <= 1'b0;
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_id_q    <= '0;
      w_err_q   <= 1'b0;
      w_atop_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_lat_q   <= r_lat_d;
      r_id_q    <= r_id_d;
      r_err_q   <= r_err_d;
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_id_q    <= w_id_d;
      w_err_q   <= w_err_d;
      w_atop_q  <= w_atop_d;
    end
  end

  // NOTE: the array has no reset; contents survive rst_ni and it maps to plain RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < StrbW; b++) begin
        if (axi_req_i.w.strb[b]) mem[w_idx_q][b*8 +: 8] <= axi_req_i.w.data[b*8 +: 8];
      end
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_lat_d   = r_lat_q;
    r_id_d    = r_id_q;
    r_err_d   = r_err_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (axi_req_i.ar_valid) begin
          r_id_d    = axi_req_i.ar.id;
          r_len_d   = axi_req_i.ar.len;
          r_cnt_d   = '0;
          r_lat_d   = '0;
          r_idx_d   = addr_to_idx(axi_req_i.ar.addr);
          r_err_d   = (axi_req_i.ar.burst != BurstIncr);
          r_state_d = (ReadLatency == 0) ? R_BURST : R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_lat_q == LatLast) r_state_d = R_BURST;
        else                    r_lat_d   = r_lat_q + 4'd1;
      end
      R_BURST: begin
        if (axi_req_i.r_ready) begin
          r_idx_d = r_idx_q + idx_t'(1);
          r_cnt_d = r_cnt_q + 8'd1;
          if (r_cnt_q == r_len_q) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_id_d    = w_id_q;
    w_err_d   = w_err_q;
    w_atop_d  = w_atop_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (axi_req_i.aw_valid) begin
          w_id_d    = axi_req_i.aw.id;
          w_len_d   = axi_req_i.aw.len;
          w_cnt_d   = '0;
          w_idx_d   = addr_to_idx(axi_req_i.aw.addr);
          w_atop_d  = (axi_req_i.aw.atop != '0);
          w_err_d   = (axi_req_i.aw.burst != BurstIncr) || (axi_req_i.aw.atop != '0);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (axi_req_i.w_valid) begin
          // Atomics are drained without touching the array.
          mem_we  = !w_atop_q;
          w_idx_d = w_idx_q + idx_t'(1);
          w_cnt_d = w_cnt_q + 8'd1;
          if (axi_req_i.w.last != (w_cnt_q == w_len_q)) w_err_d = 1'b1;
          if (w_cnt_q == w_len_q) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (axi_req_i.b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Ready/valid come from state only, never from the initiator's valids.
  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.ar_ready = (r_state_q == R_IDLE);
    axi_rsp_o.aw_ready = (w_state_q == W_IDLE);
    axi_rsp_o.w_ready  = (w_state_q == W_DATA);
    axi_rsp_o.r_valid  = (r_state_q == R_BURST);
    axi_rsp_o.b_valid  = (w_state_q == W_RESP);
    if (r_state_q == R_BURST) begin
      axi_rsp_o.r.id   = r_id_q;
      axi_rsp_o.r.data = mem[r_idx_q];
      axi_rsp_o.r.resp = r_err_q ? RespSlverr : RespOkay;
      axi_rsp_o.r.last = (r_cnt_q == r_len_q);
    end
    if (w_state_q == W_RESP) begin
      axi_rsp_o.b.id   = w_id_q;
      axi_rsp_o.b.resp = w_err_q ? RespSlverr : RespOkay;
    end
  end

  assign busy_o = (r_state_q != R_IDLE) | (w_state_q != W_IDLE);

endmodule

// File: tb/tb_axi_line_mem_responder.sv
// Directed bench for axi_line_mem_responder: a vector table of write/read bursts
// plus hand-written sequences for early last, atomics, collisions and reset.
module tb_axi_line_mem_responder;
  import axi_line_mem_pkg::*;

  localparam int unsigned NumWords    = 16;
  localparam int unsigned ReadLatency = 2;

  logic     clk;
  logic     rst_n;
  axi_req_t req;
  axi_rsp_t rsp;
  logic     busy;

  int n_checks = 0;
  int n_errors = 0;

  axi_line_mem_responder #(
    .NumWords   (NumWords),
    .ReadLatency(ReadLatency)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .axi_req_i(req),
    .axi_rsp_o(rsp),
    .busy_o   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic             wr;
    logic [63:0]      addr;
    logic [3:0]       id;
    logic [7:0]       len;
    logic [1:0]       burst;
    logic [7:0]       strb;
    logic [3:0][63:0] data;
    logic [1:0]       exp_resp;
    logic             bp;
    int               stall;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ar(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                        input logic [1:0] burst);
    req.ar.addr  = addr;
    req.ar.id    = id;
    req.ar.len   = len;
    req.ar.size  = 3'd3;
    req.ar.burst = burst;
  endtask

  task automatic set_aw(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                        input logic [1:0] burst, input logic [5:0] atop);
    req.aw.addr  = addr;
    req.aw.id    = id;
    req.aw.len   = len;
    req.aw.size  = 3'd3;
    req.aw.burst = burst;
    req.aw.atop  = atop;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [5:0] atop, input logic [7:0] strb,
                          input logic [3:0][63:0] data, input int last_at, input int b_stall,
                          input logic [1:0] exp_resp);
    set_aw(addr, id, len, burst, atop);
    req.aw_valid = 1'b1;
    for (int n = 0; !rsp.aw_ready && n < 50; n++) step();
    check("aw_ready", rsp.aw_ready, 1'b1);
    step();
    req.aw_valid = 1'b0;
    check("w_ready_after_aw", rsp.w_ready, 1'b1);
    for (int b = 0; b <= int'(len); b++) begin
      req.w.data  = data[b];
      req.w.strb  = strb;
      req.w.last  = (b == last_at);
      req.w_valid = 1'b1;
      for (int n = 0; !rsp.w_ready && n < 50; n++) step();
      check("w_ready_beat", rsp.w_ready, 1'b1);
      step();
    end
    req.w_valid = 1'b0;
    req.w.last  = 1'b0;
    check("b_valid_after_last_w", rsp.b_valid, 1'b1);
    for (int s = 0; s < b_stall; s++) begin
      step();
      check("b_valid_held", rsp.b_valid, 1'b1);
    end
    req.b_ready = 1'b1;
    check("b_id", rsp.b.id, id);
    check("b_resp", rsp.b.resp, exp_resp);
    step();
    req.b_ready = 1'b0;
    check("b_valid_after_b", rsp.b_valid, 1'b0);
    check("aw_ready_after_b", rsp.aw_ready, 1'b1);
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input logic [3:0][63:0] exp,
                         input logic [1:0] exp_resp, input logic bp);
    int lat;
    set_ar(addr, id, len, burst);
    req.ar_valid = 1'b1;
    for (int n = 0; !rsp.ar_ready && n < 50; n++) step();
    check("ar_ready", rsp.ar_ready, 1'b1);
    step();
    req.ar_valid = 1'b0;
    lat = 1;
    while (!rsp.r_valid && lat < 50) begin
      step();
      lat++;
    end
    check("r_latency", 64'(lat), 64'(1 + ReadLatency));
    for (int b = 0; b <= int'(len); b++) begin
      if (bp && b > 0) begin
        req.r_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
          check("r_valid_stalled", rsp.r_valid, 1'b1);
          check("r_data_stalled", rsp.r.data, exp[b]);
          check("r_last_stalled", rsp.r.last, (b == int'(len)));
          step();
        end
      end
      req.r_ready = 1'b1;
      check("r_valid", rsp.r_valid, 1'b1);
      check("r_data", rsp.r.data, exp[b]);
      check("r_last", rsp.r.last, (b == int'(len)));
      check("r_id", rsp.r.id, id);
      check("r_resp", rsp.r.resp, exp_resp);
      step();
      req.r_ready = 1'b0;
    end
    check("r_valid_after_last", rsp.r_valid, 1'b0);
    check("ar_ready_after_last", rsp.ar_ready, 1'b1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 64'h100, 4'd5, 8'd3, BurstIncr,  8'hFF,
                {64'h44, 64'h33, 64'h22, 64'h11}, RespOkay, 1'b0, 5};
    vecs[1] = '{1'b0, 64'h100, 4'd5, 8'd3, BurstIncr,  8'hFF,
                {64'h44, 64'h33, 64'h22, 64'h11}, RespOkay, 1'b1, 0};
    vecs[2] = '{1'b1, 64'h0,   4'd1, 8'd0, BurstIncr,  8'hFF,
                {64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, RespOkay, 1'b0, 0};
    vecs[3] = '{1'b1, 64'h0,   4'd2, 8'd0, BurstIncr,  8'h0F,
                {64'h0, 64'h0, 64'h0, 64'h0}, RespOkay, 1'b0, 0};
    vecs[4] = '{1'b0, 64'h0,   4'd3, 8'd0, BurstIncr,  8'hFF,
                {64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_0000_0000}, RespOkay, 1'b0, 0};
    vecs[5] = '{1'b0, 64'h8,   4'd4, 8'd2, BurstWrap,  8'hFF,
                {64'h0, 64'h44, 64'h33, 64'h22}, RespSlverr, 1'b0, 0};
    vecs[6] = '{1'b1, 64'h78,  4'd6, 8'd0, BurstIncr,  8'hFF,
                {64'h0, 64'h0, 64'h0, 64'h0F15}, RespOkay, 1'b0, 0};
    vecs[7] = '{1'b0, 64'h78,  4'd7, 8'd1, BurstIncr,  8'hFF,
                {64'h0, 64'h0, 64'hFFFF_FFFF_0000_0000, 64'h0F15}, RespOkay, 1'b0, 0};
    vecs[8] = '{1'b1, 64'h20,  4'd8, 8'd1, BurstFixed, 8'hFF,
                {64'h0, 64'h0, 64'hB0B0, 64'hA0A0}, RespSlverr, 1'b0, 0};
    vecs[9] = '{1'b0, 64'h20,  4'd9, 8'd1, BurstIncr,  8'hFF,
                {64'h0, 64'h0, 64'hB0B0, 64'hA0A0}, RespOkay, 1'b0, 0};

    req   = '0;
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_ar_ready", rsp.ar_ready, 1'b1);
    check("rst_aw_ready", rsp.aw_ready, 1'b1);
    check("rst_w_ready", rsp.w_ready, 1'b0);
    check("rst_b_valid", rsp.b_valid, 1'b0);
    check("rst_r_valid", rsp.r_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr)
        do_write(vecs[i].addr, vecs[i].id, vecs[i].len, vecs[i].burst, 6'h0, vecs[i].strb,
                 vecs[i].data, int'(vecs[i].len), vecs[i].stall, vecs[i].exp_resp);
      else
        do_read(vecs[i].addr, vecs[i].id, vecs[i].len, vecs[i].burst, vecs[i].data,
                vecs[i].exp_resp, vecs[i].bp);
      step();
    end

    // w.last early on beat 1: error reported, all four beats still land.
    do_write(64'h40, 4'hA, 8'd3, BurstIncr, 6'h0, 8'hFF, {64'h4, 64'h3, 64'h2, 64'h1},
             1, 0, RespSlverr);
    do_read(64'h40, 4'hB, 8'd3, BurstIncr, {64'h4, 64'h3, 64'h2, 64'h1}, RespOkay, 1'b0);

    // W offered before AW must stall, then an atomic write leaves the array alone.
    req.w.data  = 64'hDEAD;
    req.w.strb  = 8'hFF;
    req.w.last  = 1'b1;
    req.w_valid = 1'b1;
    for (int s = 0; s < 2; s++) begin
      check("w_ready_before_aw", rsp.w_ready, 1'b0);
      step();
    end
    do_write(64'h40, 4'hC, 8'd0, BurstIncr, 6'h20, 8'hFF, {64'h0, 64'h0, 64'h0, 64'hDEAD},
             0, 0, RespSlverr);
    check("atop_no_r_valid", rsp.r_valid, 1'b0);
    check("atop_idle", busy, 1'b0);
    do_read(64'h40, 4'hD, 8'd0, BurstIncr, {64'h0, 64'h0, 64'h0, 64'h1}, RespOkay, 1'b0);

    // AR and AW to the same word in the same cycle; the coincident R beat sees old data.
    do_write(64'h50, 4'h1, 8'd1, BurstIncr, 6'h0, 8'hFF, {64'h0, 64'h0, 64'hBBBB, 64'hAAAA},
             1, 0, RespOkay);
    set_ar(64'h50, 4'h3, 8'd1, BurstIncr);
    set_aw(64'h50, 4'h4, 8'd0, BurstIncr, 6'h0);
    req.ar_valid = 1'b1;
    req.aw_valid = 1'b1;
    check("coll_ar_ready", rsp.ar_ready, 1'b1);
    check("coll_aw_ready", rsp.aw_ready, 1'b1);
    step();
    req.ar_valid = 1'b0;
    req.aw_valid = 1'b0;
    step();
    step();
    check("coll_r_valid", rsp.r_valid, 1'b1);
    check("coll_w_ready", rsp.w_ready, 1'b1);
    req.w.data  = 64'hCCCC;
    req.w.strb  = 8'hFF;
    req.w.last  = 1'b1;
    req.w_valid = 1'b1;
    req.r_ready = 1'b1;
    check("coll_old_data", rsp.r.data, 64'hAAAA);
    step();
    req.w_valid = 1'b0;
    check("coll_beat1_data", rsp.r.data, 64'hBBBB);
    check("coll_beat1_last", rsp.r.last, 1'b1);
    check("coll_b_valid", rsp.b_valid, 1'b1);
    req.b_ready = 1'b1;
    check("coll_b_id", rsp.b.id, 4'h4);
    check("coll_b_resp", rsp.b.resp, RespOkay);
    step();
    req.r_ready = 1'b0;
    req.b_ready = 1'b0;
    check("coll_r_done", rsp.r_valid, 1'b0);
    check("coll_busy", busy, 1'b0);
    do_read(64'h50, 4'h5, 8'd0, BurstIncr, {64'h0, 64'h0, 64'h0, 64'hCCCC}, RespOkay, 1'b0);

    // Reset pulsed in the middle of a read burst.
    set_ar(64'h0, 4'h6, 8'd3, BurstIncr);
    req.ar_valid = 1'b1;
    step();
    req.ar_valid = 1'b0;
    for (int n = 0; !rsp.r_valid && n < 50; n++) step();
    check("rstmid_r_valid", rsp.r_valid, 1'b1);
    check("rstmid_busy", busy, 1'b1);
    rst_n = 1'b0;
    step();
    check("rstmid_ar_ready", rsp.ar_ready, 1'b1);
    check("rstmid_r_valid_low", rsp.r_valid, 1'b0);
    check("rstmid_busy_low", busy, 1'b0);
    rst_n = 1'b1;
    step();
    do_read(64'h0, 4'h7, 8'd0, BurstIncr, {64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_0000_0000},
            RespOkay, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
